// File: rtl/cordic_pkg.sv
// Shared types and helpers for the CORDIC quadrant pre-rotation stage.
package cordic_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_t;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } mode_t;

  // Negate a sign-extended w-bit value; the most negative code clamps to the
  // largest positive code instead of wrapping back onto itself.
  function automatic logic signed [MAX_W-1:0] sat_neg(input logic signed [MAX_W-1:0] v,
                                                       input int w);
    logic signed [MAX_W-1:0] most_neg;
    most_neg = -(64'sd1 <<< (w - 1));
    if (v == most_neg) sat_neg = ~most_neg;
    else               sat_neg = -v;
  endfunction

endpackage

// File: rtl/cordic_quad_map.sv
// Combinational quadrant selection and vector remapping into the right half-plane.
module cordic_quad_map
  import cordic_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ANG_W  = 16
) (
  input  logic                     mode,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y,
  input  logic        [ANG_W-1:0]  theta,
  output logic signed [DATA_W-1:0] x_map,
  output logic signed [DATA_W-1:0] y_map,
  output logic        [ANG_W-1:0]  theta_map,
  output logic        [1:0]        quad,
  output logic                     sat
);

  quad_t                     q;
  logic signed [DATA_W-1:0]  neg_x;
  logic signed [DATA_W-1:0]  neg_y;
  logic                      x_min;
  logic                      y_min;

  assign neg_x = DATA_W'(sat_neg(MAX_W'(x), DATA_W));
  assign neg_y = DATA_W'(sat_neg(MAX_W'(y), DATA_W));
  assign x_min = (x == {1'b1, {(DATA_W-1){1'b0}}});
  assign y_min = (y == {1'b1, {(DATA_W-1){1'b0}}});
  assign quad  = q;

  always_comb begin
    q         = Q0;
    theta_map = '0;
    if (mode_t'(mode) == MODE_VEC) begin
      case ({x[DATA_W-1], y[DATA_W-1]})
        2'b00:   q = Q0;
        2'b10:   q = Q1;
        2'b11:   q = Q2;
        default: q = Q3;
      endcase
      theta_map = {q, {(ANG_W-2){1'b0}}};
    end else begin
      q         = quad_t'(theta[ANG_W-1:ANG_W-2]);
      theta_map = {2'b00, theta[ANG_W-3:0]};
    end
  end

  // Each quadrant rotates by -q*90 degrees; saturation only matters for negated terms.
  always_comb begin
    x_map = x;
    y_map = y;
    sat   = 1'b0;
    case (q)
      Q0: begin
        x_map = x;
        y_map = y;
      end
      Q1: begin
        x_map = y;
        y_map = neg_x;
        sat   = x_min;
      end
      Q2: begin
        x_map = neg_x;
        y_map = neg_y;
        sat   = x_min | y_min;
      end
      default: begin
        x_map = neg_y;
        y_map = x;
        sat   = y_min;
      end
    endcase
  end

endmodule

// File: rtl/cordic_quadrant_prerotator.sv
// Quadrant pre-rotator: one-cycle mapping stage with an output register plus one skid entry.
module cordic_quadrant_prerotator
  import cordic_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ANG_W  = 16,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic        [ANG_W-1:0]  theta_in,
  input  logic        [TAG_W-1:0]  tag_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] x_out,
  output logic signed [DATA_W-1:0] y_out,
  output logic        [ANG_W-1:0]  theta_out,
  output logic        [1:0]        quad_out,
  output logic                     mode_out,
  output logic        [TAG_W-1:0]  tag_out,
  output logic        [15:0]       sat_count
);

  logic signed [DATA_W-1:0] map_x;
  logic signed [DATA_W-1:0] map_y;
  logic        [ANG_W-1:0]  map_theta;
  logic        [1:0]        map_quad;
  logic                     map_sat;

  logic                     skid_full;
  logic signed [DATA_W-1:0] skid_x;
  logic signed [DATA_W-1:0] skid_y;
  logic        [ANG_W-1:0]  skid_theta;
  logic        [1:0]        skid_quad;
  logic                     skid_mode;
  logic        [TAG_W-1:0]  skid_tag;

  logic in_xfer;
  logic out_free;
  logic load_from_skid;
  logic load_from_in;
  logic load_skid;
  logic skid_full_nxt;
  logic out_valid_nxt;

  cordic_quad_map #(
    .DATA_W(DATA_W),
    .ANG_W (ANG_W)
  ) u_map (
    .mode     (in_mode),
    .x        (x_in),
    .y        (y_in),
    .theta    (theta_in),
    .x_map    (map_x),
    .y_map    (map_y),
    .theta_map(map_theta),
    .quad     (map_quad),
    .sat      (map_sat)
  );

  // The output register frees up when it is empty or being drained; the skid
  // entry always has priority over a fresh sample so ordering is preserved.
  always_comb begin
    in_xfer        = in_valid & in_ready;
    out_free       = ~out_valid | out_ready;
    load_from_skid = out_free & skid_full;
    load_from_in   = out_free & ~skid_full & in_xfer;
    load_skid      = in_xfer & ~load_from_in;
    skid_full_nxt  = skid_full;
    if (load_skid)           skid_full_nxt = 1'b1;
    else if (load_from_skid) skid_full_nxt = 1'b0;
    out_valid_nxt  = out_free ? (skid_full | in_xfer) : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      skid_full  <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      theta_out  <= '0;
      quad_out   <= '0;
      mode_out   <= 1'b0;
      tag_out    <= '0;
      skid_x     <= '0;
      skid_y     <= '0;
      skid_theta <= '0;
      skid_quad  <= '0;
      skid_mode  <= 1'b0;
      skid_tag   <= '0;
      sat_count  <= '0;
    end else begin
      in_ready  <= ~skid_full_nxt;
      out_valid <= out_valid_nxt;
      skid_full <= skid_full_nxt;
      if (load_from_skid) begin
        x_out     <= skid_x;
        y_out     <= skid_y;
        theta_out <= skid_theta;
        quad_out  <= skid_quad;
        mode_out  <= skid_mode;
        tag_out   <= skid_tag;
      end else if (load_from_in) begin
        x_out     <= map_x;
        y_out     <= map_y;
        theta_out <= map_theta;
        quad_out  <= map_quad;
        mode_out  <= in_mode;
        tag_out   <= tag_in;
      end
      if (load_skid) begin
        skid_x     <= map_x;
        skid_y     <= map_y;
        skid_theta <= map_theta;
        skid_quad  <= map_quad;
        skid_mode  <= in_mode;
        skid_tag   <= tag_in;
      end
      if (in_xfer && map_sat && (sat_count != 16'hFFFF))
        sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cordic_quadrant_prerotator.sv
// Scoreboard bench for cordic_quadrant_prerotator using hand-computed directed vectors.
module tb_cordic_quadrant_prerotator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic [15:0] theta_in;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x_out;
  logic [15:0] y_out;
  logic [15:0] theta_out;
  logic [1:0]  quad_out;
  logic        mode_out;
  logic [3:0]  tag_out;
  logic [15:0] sat_count;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] theta;
    logic [1:0]  quad;
    logic        mode;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   tests    = 0;
  int   failures = 0;
  bit   rand_ready  = 1'b0;
  bit   fixed_ready = 1'b1;
  bit   chk_ready   = 1'b0;

  cordic_quadrant_prerotator #(
    .DATA_W(16),
    .ANG_W (16),
    .TAG_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .x_in     (x_in),
    .y_in     (y_in),
    .theta_in (theta_in),
    .tag_in   (tag_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out    (x_out),
    .y_out    (y_out),
    .theta_out(theta_out),
    .quad_out (quad_out),
    .mode_out (mode_out),
    .tag_out  (tag_out),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one sample at posedge+1 and hold it until accepted; returns at posedge+1 after the transfer.
  task automatic applyStimulus(input logic m, input logic [15:0] x, input logic [15:0] y,
                               input logic [15:0] th, input logic [3:0] tg,
                               input logic [15:0] ex, input logic [15:0] ey,
                               input logic [15:0] eth, input logic [1:0] eq);
    exp_t e;
    bit   accepted = 1'b0;
    in_valid = 1'b1;
    in_mode  = m;
    x_in     = x;
    y_in     = y;
    theta_in = th;
    tag_in   = tg;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin
        e.x = ex; e.y = ey; e.theta = eth; e.quad = eq; e.mode = m; e.tag = tg;
        sb.push_back(e);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
      if (accepted) break;
    end
    if (!accepted) begin
      tests++;
      failures++;
      $display("[TB] FAIL accept_timeout tag %0d: in_ready stayed 0, expected 1", tg);
    end
  endtask

  task automatic waitDrain(input string name);
    for (int c = 0; c < 300; c++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checkOutput(name, sb.size(), 0);
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    end
  end

  // Monitor: pops the scoreboard on every output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_ready && !in_ready)
        checkOutput("in_ready_low_only_when_full", out_valid, 1);
      if (rst !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          failures++;
          $display("[TB] FAIL unexpected_output: got tag %0d, expected no output", tag_out);
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("x_out tag%0d", e.tag), x_out, e.x);
          checkOutput($sformatf("y_out tag%0d", e.tag), y_out, e.y);
          checkOutput($sformatf("theta_out tag%0d", e.tag), theta_out, e.theta);
          checkOutput($sformatf("quad_out tag%0d", e.tag), quad_out, e.quad);
          checkOutput($sformatf("mode_out tag%0d", e.tag), mode_out, e.mode);
          checkOutput("tag_out order", tag_out, e.tag);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
    x_in = '0; y_in = '0; theta_in = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset sat_count", sat_count, 0);
    checkOutput("reset payload", {x_out, y_out}, 0);
    checkOutput("reset theta/quad/mode/tag", {theta_out, quad_out, mode_out, tag_out}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("in_ready after reset", in_ready, 1);

    $display("[TB] directed vectors");
    fixed_ready = 1'b1;
    applyStimulus(0, 16'h4000, 16'h0000, 16'h5000, 4'd1, 16'h0000, 16'hC000, 16'h1000, 2'd1);
    checkOutput("latency one cycle", out_valid, 1);
    applyStimulus(1, 16'hC000, 16'hC000, 16'h1234, 4'd2, 16'h4000, 16'h4000, 16'h8000, 2'd2);
    applyStimulus(0, 16'h8000, 16'h0000, 16'h8000, 4'd3, 16'h7FFF, 16'h0000, 16'h0000, 2'd2);
    checkOutput("sat_count after neg of min", sat_count, 1);
    applyStimulus(0, 16'h1234, 16'h8000, 16'hFFFF, 4'd4, 16'h7FFF, 16'h1234, 16'h3FFF, 2'd3);
    applyStimulus(0, 16'h8000, 16'h8000, 16'h0000, 4'd5, 16'h8000, 16'h8000, 16'h0000, 2'd0);
    checkOutput("sat_count q0 no negation", sat_count, 2);
    applyStimulus(1, 16'h0000, 16'h0000, 16'hFFFF, 4'd6, 16'h0000, 16'h0000, 16'h0000, 2'd0);
    applyStimulus(1, 16'h0000, 16'hFFFF, 16'h0000, 4'd7, 16'h0001, 16'h0000, 16'hC000, 2'd3);
    applyStimulus(1, 16'h8000, 16'h0100, 16'h0000, 4'd8, 16'h0100, 16'h7FFF, 16'h4000, 2'd1);
    checkOutput("sat_count vectoring sat", sat_count, 3);
    applyStimulus(0, 16'h0003, 16'hFFFE, 16'h7ABC, 4'd9, 16'hFFFE, 16'hFFFD, 16'h3ABC, 2'd1);
    in_valid = 1'b0;
    waitDrain("drain directed");

    $display("[TB] ordered stream with random out_ready");
    rand_ready = 1'b1;
    chk_ready  = 1'b1;
    for (int t = 0; t < 10; t++)
      applyStimulus(0, 16'(t), 16'h0000, 16'h0000, 4'(t), 16'(t), 16'h0000, 16'h0000, 2'd0);
    in_valid = 1'b0;
    waitDrain("drain stream");
    chk_ready   = 1'b0;
    rand_ready  = 1'b0;
    fixed_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no extra output after stream", out_valid, 0);

    $display("[TB] stall with out_ready low");
    fixed_ready = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(0, 16'h0AAA, 16'h0555, 16'h0000, 4'hA, 16'h0AAA, 16'h0555, 16'h0000, 2'd0);
    applyStimulus(0, 16'h0BBB, 16'h0000, 16'h0000, 4'hB, 16'h0BBB, 16'h0000, 16'h0000, 2'd0);
    in_valid = 1'b1; x_in = 16'h0CCC; y_in = '0; theta_in = '0; tag_in = 4'hC;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("stall in_ready c%0d", c), in_ready, 0);
      checkOutput($sformatf("stall x_out c%0d", c), x_out, 16'h0AAA);
      checkOutput($sformatf("stall tag_out c%0d", c), tag_out, 4'hA);
      checkOutput($sformatf("stall out_valid c%0d", c), out_valid, 1);
      @(posedge clk);
      #1;
    end
    checkOutput("stall accepted count", sb.size(), 2);

    $display("[TB] reset with both buffers full");
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    checkOutput("midreset out_valid", out_valid, 0);
    checkOutput("midreset sat_count", sat_count, 0);
    checkOutput("midreset in_ready", in_ready, 0);
    checkOutput("midreset payload", {x_out, y_out}, 0);
    checkOutput("midreset theta/quad/mode/tag", {theta_out, quad_out, mode_out, tag_out}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("in_ready after midreset", in_ready, 1);
    checkOutput("out_valid after midreset", out_valid, 0);
    fixed_ready = 1'b1;
    applyStimulus(0, 16'h8000, 16'h0000, 16'h8000, 4'd3, 16'h7FFF, 16'h0000, 16'h0000, 2'd2);
    in_valid = 1'b0;
    checkOutput("sat_count restarts", sat_count, 1);
    waitDrain("drain after reset");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no stale output after reset", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
